// File: rtl/auth_initiator_pkg.sv
// auth_initiator_pkg
//   Shared constants for the authentication initiator: header geometry,
//   request/response/ERROR type codes, err_code values and the one-hot
//   initiator state encoding.
package auth_initiator_pkg;

  localparam int HDR_FIELD_W    = 8;
  localparam int NUM_HDR_FIELDS = 4;

  localparam logic [1:0] CMD_GET_DIGESTS     = 2'd0;
  localparam logic [1:0] CMD_GET_CERTIFICATE = 2'd1;
  localparam logic [1:0] CMD_CHALLENGE       = 2'd2;
  localparam logic [1:0] CMD_INVALID         = 2'd3;

  localparam logic [HDR_FIELD_W-1:0] REQ_GET_DIGESTS      = 8'h81;
  localparam logic [HDR_FIELD_W-1:0] REQ_GET_CERTIFICATE  = 8'h82;
  localparam logic [HDR_FIELD_W-1:0] REQ_CHALLENGE        = 8'h83;
  localparam logic [HDR_FIELD_W-1:0] RESP_DIGESTS         = 8'h01;
  localparam logic [HDR_FIELD_W-1:0] RESP_CERTIFICATE     = 8'h02;
  localparam logic [HDR_FIELD_W-1:0] RESP_CHALLENGE_AUTH  = 8'h03;
  localparam logic [HDR_FIELD_W-1:0] RESP_ERROR           = 8'h7F;
  localparam logic [HDR_FIELD_W-1:0] REQ_TO_RESP_OFFSET   = 8'h80;

  localparam logic [2:0] ERR_NONE        = 3'd0;
  localparam logic [2:0] ERR_TIMEOUT     = 3'd1;
  localparam logic [2:0] ERR_BAD_VERSION = 3'd2;
  localparam logic [2:0] ERR_UNEXP_TYPE  = 3'd3;
  localparam logic [2:0] ERR_RESP_ERROR  = 3'd4;
  localparam logic [2:0] ERR_INVALID_CMD = 3'd5;

  localparam int SIZE_OF_STATES_INIT = 5;

  typedef enum logic [SIZE_OF_STATES_INIT-1:0] {
    S_IDLE      = 5'b00001,
    S_WAIT_RESP = 5'b00010,
    S_CHECK     = 5'b00100,
    S_ACK_RESP  = 5'b01000,
    S_FINISH    = 5'b10000
  } init_state_e;

  // A response type is its request type with the request bit removed.
  function automatic logic [HDR_FIELD_W-1:0] resp_type_for(
    input logic [HDR_FIELD_W-1:0] req_type
  );
    return req_type - REQ_TO_RESP_OFFSET;
  endfunction

endpackage

// File: rtl/auth_initiator_resp_check.sv
// auth_resp_check
//   Combinational validation of a captured response header.
//   Ports:
//     resp_ver, resp_type, resp_param1 : captured response header fields
//     exp_type                         : response type expected for the request
//     err_code                         : classification (ERR_* codes)
//     resp_err                         : responder ERROR Param1, else 0
module auth_resp_check
  import auth_initiator_pkg::*;
#(
  parameter int HDR_W            = 8,
  parameter int PROTOCOL_VERSION = 1
) (
  input  logic [HDR_W-1:0] resp_ver,
  input  logic [HDR_W-1:0] resp_type,
  input  logic [HDR_W-1:0] resp_param1,
  input  logic [HDR_W-1:0] exp_type,
  output logic [2:0]       err_code,
  output logic [HDR_W-1:0] resp_err
);

  // Version mismatch outranks everything: a foreign-version header cannot
  // be trusted to carry a meaningful type field.
  always_comb begin
    err_code = ERR_NONE;
    resp_err = '0;
    if (resp_ver != HDR_W'(PROTOCOL_VERSION)) begin
      err_code = ERR_BAD_VERSION;
    end else if (resp_type == RESP_ERROR) begin
      err_code = ERR_RESP_ERROR;
      resp_err = resp_param1;
    end else if (resp_type != exp_type) begin
      err_code = ERR_UNEXP_TYPE;
    end
  end

endmodule

// File: rtl/auth_initiator.sv
// auth_initiator
//   Requesting end of the Type-C authentication exchange. Builds a request
//   from a host command, holds init_req_out until the responder answers or
//   the timeout expires, validates the response header, acknowledges the
//   responder and reports the result.
//   Ports:
//     clk, reset                    : clock, synchronous active-high reset
//     start, cmd, param1, param2,
//     req_payload                   : host command
//     init_req_out, auth_msg_init_out : request to responder
//     resp_req_in, auth_msg_resp_in : response from responder
//     ack_out                       : one-cycle acknowledge to responder
//     busy, done, error, err_code,
//     resp_err, resp_param1/2,
//     resp_payload                  : status and captured response to host
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | waiting for start
//   WAIT_RESP | request driven, timeout counter running
//   CHECK     | validate captured response header
//   ACK_RESP  | ack_out pulse, also sent on errors
//   FINISH    | done pulse, result valid
module auth_initiator
  import auth_initiator_pkg::*;
#(
  parameter int MSG_LEN          = 256,
  parameter int HDR_W            = 8,
  parameter int PROTOCOL_VERSION = 1,
  parameter int TIMEOUT_CYCLES   = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            cmd,
  input  logic [7:0]            param1,
  input  logic [7:0]            param2,
  input  logic [MSG_LEN-33:0]   req_payload,
  output logic                  init_req_out,
  output logic [MSG_LEN-1:0]    auth_msg_init_out,
  input  logic                  resp_req_in,
  input  logic [MSG_LEN-1:0]    auth_msg_resp_in,
  output logic                  ack_out,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            err_code,
  output logic [7:0]            resp_err,
  output logic [7:0]            resp_param1,
  output logic [7:0]            resp_param2,
  output logic [MSG_LEN-33:0]   resp_payload
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  init_state_e state, state_next;

  logic [CNT_W-1:0]         cnt, cnt_next;
  logic [MSG_LEN-1:0]       msg_next;
  logic [MSG_LEN-1:0]       resp_msg, resp_msg_next;
  logic                     error_next;
  logic [2:0]               err_code_next;
  logic [7:0]               resp_err_next;
  logic [7:0]               resp_param1_next, resp_param2_next;
  logic [MSG_LEN-33:0]      resp_payload_next;
  logic [2:0]               chk_err_code;
  logic [HDR_W-1:0]         chk_resp_err;

  auth_resp_check #(
    .HDR_W            (HDR_W),
    .PROTOCOL_VERSION (PROTOCOL_VERSION)
  ) u_check (
    .resp_ver    (resp_msg[MSG_LEN-1 -: HDR_W]),
    .resp_type   (resp_msg[MSG_LEN-HDR_W-1 -: HDR_W]),
    .resp_param1 (resp_msg[MSG_LEN-2*HDR_W-1 -: HDR_W]),
    .exp_type    (resp_type_for(auth_msg_init_out[MSG_LEN-HDR_W-1 -: HDR_W])),
    .err_code    (chk_err_code),
    .resp_err    (chk_resp_err)
  );

  always_comb begin
    state_next        = state;
    cnt_next          = cnt;
    msg_next          = auth_msg_init_out;
    resp_msg_next     = resp_msg;
    error_next        = error;
    err_code_next     = err_code;
    resp_err_next     = resp_err;
    resp_param1_next  = resp_param1;
    resp_param2_next  = resp_param2;
    resp_payload_next = resp_payload;

    case (state)
      S_IDLE: begin
        if (start) begin
          error_next    = 1'b0;
          err_code_next = ERR_NONE;
          resp_err_next = '0;
          if (cmd != CMD_INVALID) begin
            msg_next   = {HDR_W'(PROTOCOL_VERSION), REQ_GET_DIGESTS + {6'd0, cmd},
                          param1, param2, req_payload};
            cnt_next   = '0;
            state_next = S_WAIT_RESP;
          end else begin
            err_code_next = ERR_INVALID_CMD;
            state_next    = S_FINISH;
          end
        end
      end
      S_WAIT_RESP: begin
        // A response arriving on the terminal count still wins.
        if (resp_req_in) begin
          resp_msg_next = auth_msg_resp_in;
          cnt_next      = '0;
          state_next    = S_CHECK;
        end else if (cnt == CNT_LAST) begin
          err_code_next = ERR_TIMEOUT;
          cnt_next      = '0;
          state_next    = S_FINISH;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      S_CHECK: begin
        err_code_next     = chk_err_code;
        resp_err_next     = chk_resp_err;
        resp_param1_next  = resp_msg[MSG_LEN-2*HDR_W-1 -: HDR_W];
        resp_param2_next  = resp_msg[MSG_LEN-3*HDR_W-1 -: HDR_W];
        resp_payload_next = resp_msg[MSG_LEN-33:0];
        state_next        = S_ACK_RESP;
      end
      S_ACK_RESP: state_next = S_FINISH;
      S_FINISH:   state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase

    if (state_next == S_FINISH) begin
      error_next = (err_code_next != ERR_NONE);
    end
  end

  // Strobes are decoded from the next state so every output is a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      cnt               <= '0;
      resp_msg          <= '0;
      auth_msg_init_out <= '0;
      init_req_out      <= 1'b0;
      ack_out           <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      error             <= 1'b0;
      err_code          <= ERR_NONE;
      resp_err          <= '0;
      resp_param1       <= '0;
      resp_param2       <= '0;
      resp_payload      <= '0;
    end else begin
      state             <= state_next;
      cnt               <= cnt_next;
      resp_msg          <= resp_msg_next;
      auth_msg_init_out <= msg_next;
      init_req_out      <= (state_next == S_WAIT_RESP);
      ack_out           <= (state_next == S_ACK_RESP);
      busy              <= (state_next != S_IDLE);
      done              <= (state_next == S_FINISH);
      error             <= error_next;
      err_code          <= err_code_next;
      resp_err          <= resp_err_next;
      resp_param1       <= resp_param1_next;
      resp_param2       <= resp_param2_next;
      resp_payload      <= resp_payload_next;
    end
  end

endmodule
